mux4_rr_sel_gen: RTL and testbench



---
 rtl/mux4_rr_sel_gen_if.sv | 13 +
 rtl/mux4_rr_sel_gen.sv | 145 ++++++++++++++
 tb/tb_mux4_rr_sel_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mux4_rr_sel_gen_if.sv
// Select/request bundle between the round-robin select generator and its channel mux.
// The master side is the generator; the slave side supplies requests and consumes the select.
interface mux4_rr_sel_gen_if;
    logic       en;
    logic [3:0] req;
    logic       s0;
    logic       s1;
    logic       valid;
    logic       sw;

    modport master (input en, input req, output s0, output s1, output valid, output sw);
    modport slave  (output en, output req, input s0, input s1, input valid, input sw);
endinterface

// File: rtl/mux4_rr_sel_gen.sv
// Round-robin select generator for a 4:1 channel mux with a programmable dwell per grant.
// Define MUX_GAP_EN for break-before-make: one GAP cycle with valid low between grants.
module mux4_rr_sel_gen #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux4_rr_sel_gen_if.master    bus
);

`ifdef MUX_GAP_EN
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    typedef struct packed {
        logic       found;
        logic [1:0] ch;
    } pick_t;

    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    sel_q, sel_d;
    logic          valid_q, valid_d;
    logic          sw_q, sw_d;

    pick_t         from_last;
    pick_t         from_cur;
    logic          grant_end;

    // Scan p+1, p+2, p+3, p (mod 4); the first requester wins.
    function automatic pick_t rr_pick(input logic [1:0] p, input logic [3:0] r);
        pick_t      res;
        logic [1:0] idx;
        res = '{found: 1'b0, ch: p};
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!res.found && r[idx]) begin
                res.found = 1'b1;
                res.ch    = idx;
            end
        end
        return res;
    endfunction

    assign from_last = rr_pick(last_q, bus.req);
    assign from_cur  = rr_pick(sel_q, bus.req);
    // Dwell expiry and the owner dropping its request collapse into one end-of-grant.
    assign grant_end = (cnt_q == '0) || !bus.req[sel_q];

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        sw_d    = 1'b0;

        if (bus.en) begin
            unique case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    if (from_last.found) begin
                        state_d = GRANT;
                        sel_d   = from_last.ch;
                        cnt_d   = RELOAD;
                        valid_d = 1'b1;
                        sw_d    = 1'b1;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        last_d = sel_q;
                        if (from_cur.found) begin
`ifdef MUX_GAP_EN
                            state_d = GAP;
                            valid_d = 1'b0;
`else
                            sel_d   = from_cur.ch;
                            cnt_d   = RELOAD;
                            valid_d = 1'b1;
                            sw_d    = 1'b1;
`endif
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
`ifdef MUX_GAP_EN
                // last_q already holds the old owner, so this re-search sees current req.
                GAP: begin
                    if (from_last.found) begin
                        state_d = GRANT;
                        sel_d   = from_last.ch;
                        cnt_d   = RELOAD;
                        valid_d = 1'b1;
                        sw_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            sw_q    <= sw_d;
        end
    end

    assign bus.s1    = sel_q[1];
    assign bus.s0    = sel_q[0];
    assign bus.valid = valid_q;
    assign bus.sw    = sw_q;

endmodule

// File: tb/tb_mux4_rr_sel_gen.sv
// Scoreboard bench for mux4_rr_sel_gen: DWELL=4 and DWELL=1 instances share stimulus,
// hand-computed expectations are queued by the driver and popped by a monitor each cycle.
module tb_mux4_rr_sel_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux4_rr_sel_gen_if bus_a ();
    mux4_rr_sel_gen_if bus_b ();

    mux4_rr_sel_gen #(.DWELL(4), .CW(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mux4_rr_sel_gen #(.DWELL(1), .CW(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct packed {
        logic [1:0] a_sel;
        logic       a_v;
        logic       a_sw;
        logic [1:0] b_sel;
        logic       b_v;
        logic       b_sw;
    } exp_t;

    exp_t sb_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc_no = 0;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc_no, act, want);
        end
    endtask

    // One cycle of stimulus; expectations describe outputs after the following rising edge.
    task automatic step(input logic r, input logic e, input logic [3:0] q,
                        input logic [1:0] as_, input logic av, input logic asw,
                        input logic [1:0] bs, input logic bv, input logic bsw);
        exp_t x;
        @(negedge clk);
        rst       = r;
        bus_a.en  = e;
        bus_a.req = q;
        bus_b.en  = e;
        bus_b.req = q;
        x = '{as_, av, asw, bs, bv, bsw};
        sb_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cyc_no++;
                check("a_sel",   {bus_a.s1, bus_a.s0}, e.a_sel);
                check("a_valid", 2'(bus_a.valid),      2'(e.a_v));
                check("a_sw",    2'(bus_a.sw),         2'(e.a_sw));
                check("b_sel",   {bus_b.s1, bus_b.s0}, e.b_sel);
                check("b_valid", 2'(bus_b.valid),      2'(e.b_v));
                check("b_sw",    2'(bus_b.sw),         2'(e.b_sw));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish, cycles checked=%0d", cyc_no);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int drain;
        rst       = 1'b1;
        bus_a.en  = 1'b0;
        bus_a.req = 4'b0000;
        bus_b.en  = 1'b0;
        bus_b.req = 4'b0000;

        step(1, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
        step(1, 1, 4'b0000, 0, 0, 0, 0, 0, 0);

`ifdef MUX_GAP_EN
        // Break-before-make with req=0011 on both dwell settings.
        step(0, 1, 4'b0011, 0, 1, 1, 0, 1, 1);
        step(0, 1, 4'b0011, 0, 1, 0, 0, 0, 0);
        step(0, 1, 4'b0011, 0, 1, 0, 1, 1, 1);
        step(0, 1, 4'b0011, 0, 1, 0, 1, 0, 0);
        step(0, 1, 4'b0011, 0, 0, 0, 0, 1, 1);
        step(0, 1, 4'b0011, 1, 1, 1, 0, 0, 0);
        step(0, 1, 4'b0011, 1, 1, 0, 1, 1, 1);
        step(0, 1, 4'b0011, 1, 1, 0, 1, 0, 0);
        step(0, 1, 4'b0011, 1, 1, 0, 0, 1, 1);
        step(0, 1, 4'b0011, 1, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0011, 0, 1, 1, 1, 1, 1);
        step(0, 1, 4'b0011, 0, 1, 0, 1, 0, 0);
`else
        // No requests: parked in IDLE.
        for (int k = 0; k < 10; k++)
            step(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0);

        // All channels requesting: full rotation and wrap back to ch0.
        for (int k = 1; k <= 17; k++)
            step(0, 1, 4'b1111, 2'(((k - 1) / 4) % 4), 1, ((k - 1) % 4) == 0,
                 2'((k - 1) % 4), 1, 1);
        step(1, 1, 4'b1111, 0, 0, 0, 0, 0, 0);

        // Only channels 1 and 3 requesting.
        for (int k = 1; k <= 10; k++)
            step(0, 1, 4'b1010, (((k - 1) / 4) % 2 == 1) ? 2'd3 : 2'd1, 1, ((k - 1) % 4) == 0,
                 (k % 2 == 1) ? 2'd1 : 2'd3, 1, 1);
        step(1, 1, 4'b1010, 0, 0, 0, 0, 0, 0);

        // Owner drops its request mid-grant, then all requests go away.
        step(0, 1, 4'b0101, 0, 1, 1, 0, 1, 1);
        step(0, 1, 4'b0101, 0, 1, 0, 2, 1, 1);
        step(0, 1, 4'b0100, 2, 1, 1, 2, 1, 1);
        step(0, 1, 4'b0100, 2, 1, 0, 2, 1, 1);
        step(0, 1, 4'b0000, 2, 0, 0, 2, 0, 0);
        step(0, 1, 4'b0000, 2, 0, 0, 2, 0, 0);

        // Freeze with en=0 mid-grant, then reset and restart from ch0.
        step(0, 1, 4'b1111, 3, 1, 1, 3, 1, 1);
        step(0, 1, 4'b1111, 3, 1, 0, 0, 1, 1);
        step(0, 0, 4'b0000, 3, 1, 0, 0, 1, 0);
        step(0, 0, 4'b0000, 3, 1, 0, 0, 1, 0);
        step(0, 0, 4'b0101, 3, 1, 0, 0, 1, 0);
        step(0, 0, 4'b0010, 3, 1, 0, 0, 1, 0);
        step(0, 0, 4'b1111, 3, 1, 0, 0, 1, 0);
        step(1, 0, 4'b1111, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'b1111, 0, 1, 1, 0, 1, 1);
        step(0, 1, 4'b1111, 0, 1, 0, 1, 1, 1);
        step(0, 1, 4'b0000, 0, 0, 0, 1, 0, 0);
        step(0, 0, 4'b1111, 0, 0, 0, 1, 0, 0);
        step(0, 1, 4'b1111, 1, 1, 1, 2, 1, 1);
`endif

        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
